// File: rtl/rr_line_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin line arbiter.
package rr_line_arbiter_pkg;

  localparam int N            = 8;
  localparam int IDXW         = 3;
  localparam int MAX_HOLD_DEF = 12;
  localparam int HOLDW        = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_line_arbiter_pick.sv
// Rotating-priority search: lowest requester at or after ptr+1, wrapping 7->0.
module rr_priority_pick
  import rr_line_arbiter_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx,
  output logic [N-1:0]    onehot
);

  logic [N-1:0]    rot;
  logic [IDXW-1:0] off;

  // rot[k] is the request that sits k+1 places after the last owner
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IDXW-1:0] pos;
    assign pos     = ptr + IDXW'(gi + 1);
    assign rot[gi] = req[pos];
  end

  always_comb begin
    found  = 1'b0;
    off    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDXW'(i);
      end
    end
    idx    = ptr + off + IDXW'(1);
    onehot = '0;
    if (found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_line_arbiter.sv
// Round-robin arbiter for 8 requesters with hold limit; drives the 3-to-8 line decoder.
module rr_line_arbiter
  import rr_line_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Enable,
  input  logic [N-1:0]    Req,
  output logic [N-1:0]    Grant,
  output logic [IDXW-1:0] GrantIdx,
  output logic            GrantValid,
  output logic            DecEnable,
  output logic            A,
  output logic            B,
  output logic            C,
  output logic            Revoked
);

  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(MAX_HOLD - 1);
  localparam logic [HOLDW-1:0] HOLD_SAT  = '1;

  state_t            state_reg;
  logic [N-1:0]      grant_reg;
  logic [IDXW-1:0]   idx_reg;
  logic [IDXW-1:0]   ptr_reg;
  logic [HOLDW-1:0]  hold_cnt_reg;
  logic              valid_reg;
  logic              revoked_reg;

  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic [N-1:0]      pick_onehot;
  logic              others_waiting;

  rr_priority_pick u_pick (
    .req    (Req),
    .ptr    (ptr_reg),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign others_waiting = |(Req & ~grant_reg);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      idx_reg      <= '0;
      ptr_reg      <= IDXW'(N - 1);
      hold_cnt_reg <= '0;
      valid_reg    <= 1'b0;
      revoked_reg  <= 1'b0;
    end else begin
      revoked_reg <= 1'b0;
      if (!Enable) begin
        state_reg <= IDLE;
        grant_reg <= '0;
        idx_reg   <= '0;
        valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, RELEASE: begin
            if (pick_found) begin
              state_reg    <= GRANT;
              grant_reg    <= pick_onehot;
              idx_reg      <= pick_idx;
              valid_reg    <= 1'b1;
              ptr_reg      <= pick_idx;
              hold_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end
          GRANT: begin
            if (hold_cnt_reg != HOLD_SAT) hold_cnt_reg <= hold_cnt_reg + 1'b1;
            // >= keeps the limit effective if a waiter appears after the count saturates
            if (!Req[idx_reg]) begin
              state_reg <= RELEASE;
              grant_reg <= '0;
              idx_reg   <= '0;
              valid_reg <= 1'b0;
            end else if (hold_cnt_reg >= HOLD_LAST && others_waiting) begin
              state_reg   <= RELEASE;
              grant_reg   <= '0;
              idx_reg     <= '0;
              valid_reg   <= 1'b0;
              revoked_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            grant_reg <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Grant      = grant_reg;
  assign GrantIdx   = idx_reg;
  assign GrantValid = valid_reg;
  assign DecEnable  = valid_reg;
  assign A          = idx_reg[2];
  assign B          = idx_reg[1];
  assign C          = idx_reg[0];
  assign Revoked    = revoked_reg;

endmodule

// File: tb/tb_rr_line_arbiter.sv
// Directed table-driven bench for rr_line_arbiter plus hand-written multi-cycle sequences.
module tb_rr_line_arbiter;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Enable;
  logic [7:0] Req;
  logic [7:0] Grant;
  logic [2:0] GrantIdx;
  logic       GrantValid, DecEnable, A, B, C, Revoked;

  int total = 0;
  int bad   = 0;

  rr_line_arbiter dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Enable     (Enable),
    .Req        (Req),
    .Grant      (Grant),
    .GrantIdx   (GrantIdx),
    .GrantValid (GrantValid),
    .DecEnable  (DecEnable),
    .A          (A),
    .B          (B),
    .C          (C),
    .Revoked    (Revoked)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       rev;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic en, logic [7:0] req,
                              logic [7:0] grant, logic [2:0] idx, logic rev);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.grant = grant; v.idx = idx; v.rev = rev;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] g, input logic [2:0] idx,
                         input logic rev);
    chk({tag, " grant"},   32'(Grant), 32'(g));
    chk({tag, " idx"},     32'(GrantIdx), 32'(idx));
    chk({tag, " valid"},   32'(GrantValid), 32'(g != 8'h00));
    chk({tag, " decen"},   32'(DecEnable), 32'(g != 8'h00));
    chk({tag, " abc"},     32'({A, B, C}), 32'(idx));
    chk({tag, " revoked"}, 32'(Revoked), 32'(rev));
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    Enable = 1'b1;
    Req    = 8'h00;
    step();
    step();
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn = 1'b0;
    Enable = 1'b0;
    Req    = 8'h00;
    #2;
    chk_out("reset", 8'h00, 3'd0, 1'b0);
    do_reset();

    // single request, 1-cycle latency
    tbl.push_back(mk(0, 1, 8'h04, 8'h04, 3'd2, 0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 3'd0, 0));
    // two requesters alternate 0,7,0 with a dead cycle between owners
    tbl.push_back(mk(1, 1, 8'h00, 8'h00, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h81, 8'h01, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h81, 8'h01, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h81, 8'h01, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h80, 8'h00, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h81, 8'h80, 3'd7, 0));
    tbl.push_back(mk(0, 1, 8'h81, 8'h80, 3'd7, 0));
    tbl.push_back(mk(0, 1, 8'h81, 8'h80, 3'd7, 0));
    tbl.push_back(mk(0, 1, 8'h01, 8'h00, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 8'h01, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 8'h00, 3'd0, 0));
    // enable drop mid-grant, resume searching after retained pointer 6
    tbl.push_back(mk(1, 1, 8'h00, 8'h00, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h40, 8'h40, 3'd6, 0));
    tbl.push_back(mk(0, 0, 8'h40, 8'h00, 3'd0, 0));
    tbl.push_back(mk(0, 1, 8'h41, 8'h01, 3'd0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      Resetn = ~tbl[i].rst;
      Enable = tbl[i].en;
      Req    = tbl[i].req;
      step();
      $display("vec %0d: rst=%0b en=%0b req=%02h -> grant=%02h idx=%0d rev=%0b",
               i, tbl[i].rst, tbl[i].en, tbl[i].req, Grant, GrantIdx, Revoked);
      chk_out($sformatf("vec%0d", i), tbl[i].grant, tbl[i].idx, tbl[i].rev);
    end
    Resetn = 1'b1;

    // forced release of owner 3 after 12 grant cycles while 5 waits
    do_reset();
    Req = 8'h08;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 2) Req = 8'h28;
      chk_out($sformatf("hold c%0d", c), 8'h08, 3'd3, 1'b0);
    end
    step();
    $display("revoke: grant=%02h rev=%0b", Grant, Revoked);
    chk_out("revoke pulse", 8'h00, 3'd0, 1'b1);
    step();
    $display("after revoke: grant=%02h rev=%0b", Grant, Revoked);
    chk_out("after revoke", 8'h20, 3'd5, 1'b0);

    // lone requester is never revoked
    do_reset();
    Req = 8'h08;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk_out($sformatf("alone c%0d", c), 8'h08, 3'd3, 1'b0);
    end
    $display("alone: grant=%02h after 20 cycles", Grant);

    // async reset mid-grant clears outputs without a clock edge
    #2;
    Resetn = 1'b0;
    #1;
    $display("async reset: grant=%02h valid=%0b", Grant, GrantValid);
    chk_out("async reset", 8'h00, 3'd0, 1'b0);
    step();
    Resetn = 1'b1;
    Req    = 8'hFF;
    step();
    $display("post reset all req: grant=%02h", Grant);
    chk_out("post reset", 8'h01, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
